// File: rtl/level_seq_pkg.sv
// Shared encodings and widths for the level sequencer.
// State codes, level/score widths and the score ceiling.
package level_seq_pkg;

  localparam int STATE_W = 2;
  localparam int LEVEL_W = 4;
  localparam int SCORE_W = 8;

  localparam logic [SCORE_W-1:0] SCORE_MAX = 8'd255;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_OVER   = 2'd3
  } state_t;

endpackage

// File: rtl/level_sequencer_tick_gen.sv
// Programmable modulo counter producing a registered one-cycle tick.
// Restart has priority over counting; the tick still fires on a restart edge.
module tick_gen #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic             hit;

  assign hit = cnt >= (period - CNT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= en && hit;
      if (restart)
        cnt <= '0;
      else if (en)
        cnt <= hit ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/level_sequencer.sv
// Game-speed controller: session FSM, score/level tracking and tick divider.
// Optional idle-tick timeout is enabled with LEVEL_SEQ_TIMEOUT_EN.
module level_sequencer
  import level_seq_pkg::*;
#(
  parameter int BASE_DIV      = 50_000_000,
  parameter int STEP_DIV      = 4_000_000,
  parameter int MAX_LEVEL     = 9,
  parameter int PTS_PER_LEVEL = 10,
  parameter int CNT_W         = 26,
  parameter int TIMEOUT_TICKS = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  input  logic               point,
  input  logic               fail,
  output logic               tick,
  output logic               level_up,
  output logic [LEVEL_W-1:0] curr_level,
  output logic [SCORE_W-1:0] score,
  output logic [STATE_W-1:0] state
);

  localparam int PW =
    (PTS_PER_LEVEL > 1) ? $clog2(PTS_PER_LEVEL) : 1;
  localparam logic [PW-1:0] PTS_LAST = PW'(PTS_PER_LEVEL - 1);
  localparam logic [LEVEL_W-1:0] LVL_MAX = LEVEL_W'(MAX_LEVEL);
  localparam logic [CNT_W-1:0] BASE_C = CNT_W'(BASE_DIV);
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP_DIV);

  state_t             st;
  state_t             st_d;
  logic [LEVEL_W-1:0] level_d;
  logic [SCORE_W-1:0] score_d;
  logic [PW-1:0]      pcnt;
  logic [PW-1:0]      pcnt_d;
  logic               level_up_d;
  logic               go;
  logic               lvl_chg;
  logic               to_hit;
  logic [CNT_W-1:0]   period_q;
  logic [CNT_W-1:0]   period_d;

  assign state = st;

  always_comb begin
    st_d       = st;
    level_d    = curr_level;
    score_d    = score;
    pcnt_d     = pcnt;
    level_up_d = 1'b0;
    go         = 1'b0;
    lvl_chg    = 1'b0;
    unique case (st)
      S_IDLE, S_OVER: begin
        if (start) begin
          st_d    = S_RUN;
          go      = 1'b1;
          level_d = LEVEL_W'(1);
          score_d = '0;
          pcnt_d  = '0;
        end
      end
      S_RUN: begin
        if (fail || to_hit) begin
          st_d = S_OVER;
        end else begin
          if (pause)
            st_d = S_PAUSED;
          if (point) begin
            if (score != SCORE_MAX)
              score_d = score + SCORE_W'(1);
            if (pcnt == PTS_LAST) begin
              pcnt_d = '0;
              if (curr_level < LVL_MAX) begin
                level_d    = curr_level + LEVEL_W'(1);
                level_up_d = 1'b1;
                lvl_chg    = 1'b1;
              end
            end else begin
              pcnt_d = pcnt + PW'(1);
            end
          end
        end
      end
      S_PAUSED: begin
        if (fail)
          st_d = S_OVER;
        else if (pause)
          st_d = S_RUN;
      end
    endcase
  end

  // Period tracks the level being written this cycle.
  always_comb begin
    period_d = BASE_C - CNT_W'(level_d - LEVEL_W'(1)) * STEP_C;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st         <= S_IDLE;
      curr_level <= LEVEL_W'(1);
      score      <= '0;
      pcnt       <= '0;
      level_up   <= 1'b0;
      period_q   <= BASE_C;
    end else begin
      st         <= st_d;
      curr_level <= level_d;
      score      <= score_d;
      pcnt       <= pcnt_d;
      level_up   <= level_up_d;
      if (level_d != curr_level)
        period_q <= period_d;
    end
  end

`ifdef LEVEL_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_TICKS);

  logic [TW-1:0] idle_ticks;

  assign to_hit = (st == S_RUN) && (idle_ticks == TO_LIM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_ticks <= '0;
    end else if (go) begin
      idle_ticks <= '0;
    end else if (st == S_RUN) begin
      if (point)
        idle_ticks <= '0;
      else if (tick && !to_hit)
        idle_ticks <= idle_ticks + TW'(1);
    end
  end
`else
  // Timeout disabled: only fail ends a session.
  assign to_hit = (TIMEOUT_TICKS < 0);
`endif

  tick_gen #(
    .CNT_W(CNT_W)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .en     (st == S_RUN),
    .restart(go || lvl_chg),
    .period (period_q),
    .tick   (tick)
  );

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer with a scoreboard of expectations.
// Expected values are queued on stimulus and popped at observation.
module tb_level_sequencer;

  localparam int SEL_START = 0;
  localparam int SEL_PAUSE = 1;
  localparam int SEL_POINT = 2;
  localparam int SEL_FAIL  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       point = 1'b0;
  logic       fail = 1'b0;
  logic       tick;
  logic       level_up;
  logic [3:0] curr_level;
  logic [7:0] score;
  logic [1:0] state;

  always #5 clk = ~clk;

  level_sequencer #(
    .BASE_DIV     (20),
    .STEP_DIV     (4),
    .MAX_LEVEL    (3),
    .PTS_PER_LEVEL(2),
    .CNT_W        (8),
    .TIMEOUT_TICKS(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pause     (pause),
    .point     (point),
    .fail      (fail),
    .tick      (tick),
    .level_up  (level_up),
    .curr_level(curr_level),
    .score     (score),
    .state     (state)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = 32'(val);
    sb.push_back(e);
  endtask

  task automatic observe(input logic [31:0] obs);
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      fails++;
      $error("FAIL sb_empty observed=%0d required=entry", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      fails++;
      $error("FAIL %s observed=%0d required=%0d",
             e.tag, obs, e.val);
    end
  endtask

  task automatic pulse(input int sel);
    case (sel)
      SEL_START: start = 1'b1;
      SEL_PAUSE: pause = 1'b1;
      SEL_POINT: point = 1'b1;
      default:   fail = 1'b1;
    endcase
    cyc();
    start = 1'b0;
    pause = 1'b0;
    point = 1'b0;
    fail  = 1'b0;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      n++;
      if (tick === 1'b1)
        return;
    end
    n = -1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nt;

    #2 rst = 1'b0;
    #2;
    expect_val("rst_state", 0);    observe(32'(state));
    expect_val("rst_level", 1);    observe(32'(curr_level));
    expect_val("rst_score", 0);    observe(32'(score));
    expect_val("rst_tick", 0);     observe(32'(tick));
    expect_val("rst_lvlup", 0);    observe(32'(level_up));
    rst = 1'b1;
    cyc();

    pulse(SEL_START);
    expect_val("start_state", 1);  observe(32'(state));
    expect_val("start_level", 1);  observe(32'(curr_level));
    wait_tick(n);
    expect_val("first_tick", 20);  observe(32'(n));
    wait_tick(n);
    expect_val("period_l1", 20);   observe(32'(n));

    pulse(SEL_POINT);
    cyc();
    pulse(SEL_POINT);
    expect_val("lvlup_l2", 1);     observe(32'(level_up));
    expect_val("level_l2", 2);     observe(32'(curr_level));
    cyc();
    expect_val("lvlup_single", 0); observe(32'(level_up));
    wait_tick(n);
    expect_val("period_l2", 16);   observe(32'(n + 1));

    pulse(SEL_POINT);
    cyc();
    pulse(SEL_POINT);
    expect_val("lvlup_l3", 1);     observe(32'(level_up));
    expect_val("level_l3", 3);     observe(32'(curr_level));
    wait_tick(n);
    expect_val("period_l3", 12);   observe(32'(n));

    pulse(SEL_POINT);
    cyc();
    pulse(SEL_POINT);
    expect_val("lvlup_max", 0);    observe(32'(level_up));
    expect_val("level_max", 3);    observe(32'(curr_level));
    expect_val("score_6", 6);      observe(32'(score));

    wait_tick(n);
    fail  = 1'b1;
    point = 1'b1;
    cyc();
    fail  = 1'b0;
    point = 1'b0;
    expect_val("fail_state", 3);   observe(32'(state));
    expect_val("fail_score", 6);   observe(32'(score));
    nt = 0;
    repeat (40) begin
      cyc();
      if (tick === 1'b1) nt++;
    end
    expect_val("over_no_tick", 0); observe(32'(nt));

    pulse(SEL_START);
    expect_val("restart_state", 1); observe(32'(state));
    expect_val("restart_level", 1); observe(32'(curr_level));
    expect_val("restart_score", 0); observe(32'(score));

    wait_tick(n);
    expect_val("restart_tick", 20); observe(32'(n));
    repeat (6) cyc();
    pulse(SEL_PAUSE);
    expect_val("paused_state", 2);  observe(32'(state));
    nt = 0;
    repeat (49) begin
      cyc();
      if (tick === 1'b1) nt++;
    end
    pulse(SEL_PAUSE);
    if (tick === 1'b1) nt++;
    expect_val("resume_state", 1);  observe(32'(state));
    expect_val("paused_no_tick", 0); observe(32'(nt));
    wait_tick(n);
    expect_val("resume_tick", 13);  observe(32'(n));

    pulse(SEL_POINT);
    cyc();
    pulse(SEL_POINT);
    expect_val("pre_rst_level", 2); observe(32'(curr_level));
    #2 rst = 1'b0;
    #1;
    expect_val("arst_state", 0);   observe(32'(state));
    expect_val("arst_level", 1);   observe(32'(curr_level));
    expect_val("arst_score", 0);   observe(32'(score));
    expect_val("arst_lvlup", 0);   observe(32'(level_up));
    expect_val("arst_tick", 0);    observe(32'(tick));
    rst = 1'b1;
    cyc();

`ifdef LEVEL_SEQ_TIMEOUT_EN
    pulse(SEL_START);
    repeat (3) wait_tick(n);
    cyc();
    expect_val("to_not_yet", 1);   observe(32'(state));
    cyc();
    expect_val("to_over", 3);      observe(32'(state));

    pulse(SEL_START);
    repeat (2) wait_tick(n);
    pulse(SEL_POINT);
    repeat (2) wait_tick(n);
    repeat (2) cyc();
    expect_val("to_cleared", 1);   observe(32'(state));
    wait_tick(n);
    repeat (2) cyc();
    expect_val("to_after_pt", 3);  observe(32'(state));
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
